// File: rtl/tmds_word_aligner_pkg.sv
// Shared definitions for the TMDS word aligner: control tokens, align-state
// encodings and common widths.
package tmds_word_aligner_pkg;

    localparam int unsigned TOKEN_BITS = 10;
    localparam int unsigned LOSS_BITS  = 8;

    // DVI/HDMI control-period tokens (as they appear once deserialized LSB first)
    localparam logic [TOKEN_BITS-1:0] CTRL_00 = 10'h354;
    localparam logic [TOKEN_BITS-1:0] CTRL_01 = 10'h0AB;
    localparam logic [TOKEN_BITS-1:0] CTRL_10 = 10'h154;
    localparam logic [TOKEN_BITS-1:0] CTRL_11 = 10'h2AB;

    typedef enum logic [1:0] {
        S_SEARCH = 2'd0,
        S_VERIFY = 2'd1,
        S_LOCKED = 2'd2
    } align_state_t;

endpackage

// File: rtl/tmds_word_aligner_token_detect.sv
// Combinational recognizer for the four TMDS control tokens.
//  i_word     : candidate word, LSB = first bit on the wire
//  o_is_ctrl_c: word equals one of CTRL_00..CTRL_11
module tmds_word_aligner_token_detect
    import tmds_word_aligner_pkg::*;
#(
    parameter int unsigned WORD_BITS = 10
) (
    input  logic [WORD_BITS-1:0] i_word,
    output logic                 o_is_ctrl_c
);

    always_comb begin
        o_is_ctrl_c = (i_word == WORD_BITS'(CTRL_00)) ||
                      (i_word == WORD_BITS'(CTRL_01)) ||
                      (i_word == WORD_BITS'(CTRL_10)) ||
                      (i_word == WORD_BITS'(CTRL_11));
    end

endmodule

// File: rtl/tmds_word_aligner.sv
// Bit-serial deserializer and self-aligning word framer for TMDS lanes.
// Locks word phase on control tokens of the sync lane with hysteresis and
// emits aligned words for all lanes with a one-cycle strobe.
//  bit_clk         : bit clock, one bit per lane per edge
//  reset_n         : async active-low reset
//  in_bits         : current serial bit of each lane
//  slip            : one-cycle pulse, delays the word boundary by one bit
//  word_out        : aligned words, lane k at [k*WORD_BITS +: WORD_BITS]
//  word_valid      : one-cycle strobe, word_out updated this cycle
//  locked          : word phase trusted
//  align_state     : 0 SEARCH, 1 VERIFY, 2 LOCKED
//  lock_loss_count : saturating count of LOCKED->SEARCH exits
module tmds_word_aligner
    import tmds_word_aligner_pkg::*;
#(
    parameter int unsigned WORD_BITS    = 10,
    parameter int unsigned CHANNELS     = 3,
    parameter int unsigned SYNC_CHANNEL = 0,
    parameter int unsigned LOCK_COUNT   = 4,
    parameter int unsigned UNLOCK_COUNT = 3,
    parameter bit          AUTO_LOCK    = 1'b1
) (
    input  logic                          bit_clk,
    input  logic                          reset_n,
    input  logic [CHANNELS-1:0]           in_bits,
    input  logic                          slip,
    output logic [CHANNELS*WORD_BITS-1:0] word_out,
    output logic                          word_valid,
    output logic                          locked,
    output logic [1:0]                    align_state,
    output logic [LOSS_BITS-1:0]          lock_loss_count
);

    localparam int unsigned PHASE_BITS = (WORD_BITS > 1) ? $clog2(WORD_BITS) : 1;
    localparam int unsigned MATCH_BITS = $clog2(LOCK_COUNT + 1);
    localparam int unsigned MISS_BITS  = $clog2(UNLOCK_COUNT + 1);
    localparam logic [PHASE_BITS-1:0] PHASE_LAST = PHASE_BITS'(WORD_BITS - 1);

    logic [CHANNELS*WORD_BITS-1:0] w_nxt_flat;
    logic                          w_tok;
    logic                          w_boundary;
    logic                          w_emit;

    align_state_t                  r_state,  w_state_nxt;
    logic [PHASE_BITS-1:0]         r_phase,  w_phase_nxt;
    logic [MATCH_BITS-1:0]         r_match,  w_match_nxt;
    logic [MISS_BITS-1:0]          r_miss,   w_miss_nxt;
    logic [LOSS_BITS-1:0]          r_loss,   w_loss_nxt;
    logic [CHANNELS*WORD_BITS-1:0] r_word;
    logic                          r_valid;
    logic                          r_locked;

    // Per-lane shifter; only W-1 bits are stored, the newest bit completes the word
    for (genvar k = 0; k < CHANNELS; k++) begin : g_lane
        logic [WORD_BITS-2:0] r_sr;
        logic [WORD_BITS-1:0] w_nxt;

        assign w_nxt = {in_bits[k], r_sr};
        assign w_nxt_flat[k*WORD_BITS +: WORD_BITS] = w_nxt;

        always_ff @(posedge bit_clk or negedge reset_n) begin
            if (!reset_n) r_sr <= '0;
            else          r_sr <= w_nxt[WORD_BITS-1:1];
        end
    end

    tmds_word_aligner_token_detect #(
        .WORD_BITS (WORD_BITS)
    ) u_token_detect (
        .i_word      (w_nxt_flat[SYNC_CHANNEL*WORD_BITS +: WORD_BITS]),
        .o_is_ctrl_c (w_tok)
    );

    assign w_boundary = (r_phase == PHASE_LAST);

    // Alignment FSM state and counters
    always_ff @(posedge bit_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_SEARCH;
            r_phase <= '0;
            r_match <= '0;
            r_miss  <= '0;
            r_loss  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_phase <= w_phase_nxt;
            r_match <= w_match_nxt;
            r_miss  <= w_miss_nxt;
            r_loss  <= w_loss_nxt;
        end
    end

    // Next-state: slip freezes everything except the shifters
    always_comb begin
        w_state_nxt = r_state;
        w_phase_nxt = w_boundary ? '0 : r_phase + PHASE_BITS'(1);
        w_match_nxt = r_match;
        w_miss_nxt  = r_miss;
        w_loss_nxt  = r_loss;
        w_emit      = 1'b0;

        if (!AUTO_LOCK) w_state_nxt = S_LOCKED;

        if (slip) begin
            w_phase_nxt = r_phase;
        end else if (!AUTO_LOCK) begin
            w_emit = w_boundary;
        end else begin
            unique case (r_state)
                S_SEARCH: begin
                    // Token seen: this cycle becomes the word boundary
                    if (w_tok) begin
                        w_phase_nxt = '0;
                        w_match_nxt = MATCH_BITS'(1);
                        w_miss_nxt  = '0;
                        w_state_nxt = (LOCK_COUNT == 1) ? S_LOCKED : S_VERIFY;
                    end
                end
                S_VERIFY: begin
                    if (w_boundary) begin
                        if (!w_tok) begin
                            w_state_nxt = S_SEARCH;
                            w_match_nxt = '0;
                        end else if (r_match == MATCH_BITS'(LOCK_COUNT - 1)) begin
                            w_state_nxt = S_LOCKED;
                            w_match_nxt = '0;
                            w_miss_nxt  = '0;
                        end else begin
                            w_match_nxt = r_match + MATCH_BITS'(1);
                        end
                    end
                end
                S_LOCKED: begin
                    if (w_boundary) begin
                        w_emit = 1'b1;
                        if (w_tok) w_miss_nxt = '0;
                    end else if (w_tok) begin
                        // Off-phase token: evidence the boundary has drifted
                        if (r_miss == MISS_BITS'(UNLOCK_COUNT - 1)) begin
                            w_state_nxt = S_SEARCH;
                            w_miss_nxt  = '0;
                            w_loss_nxt  = (r_loss == '1) ? r_loss : r_loss + LOSS_BITS'(1);
                        end else begin
                            w_miss_nxt = r_miss + MISS_BITS'(1);
                        end
                    end
                end
                default: begin
                    w_state_nxt = S_SEARCH;
                    w_match_nxt = '0;
                    w_miss_nxt  = '0;
                end
            endcase
        end
    end

    // Output register: word held between strobes
    always_ff @(posedge bit_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_word   <= '0;
            r_valid  <= 1'b0;
            r_locked <= 1'b0;
        end else begin
            if (w_emit) r_word <= w_nxt_flat;
            r_valid  <= w_emit;
            r_locked <= (w_state_nxt == S_LOCKED);
        end
    end

    assign word_out        = r_word;
    assign word_valid      = r_valid;
    assign locked          = r_locked;
    assign align_state     = r_state;
    assign lock_loss_count = r_loss;

endmodule

// File: tb/tb_tmds_word_aligner.sv
// Scoreboard bench for tmds_word_aligner: auto-lock instance plus a
// free-running (AUTO_LOCK=0) instance.
module tb_tmds_word_aligner;

    localparam logic [9:0] TOK = 10'h2AB;

    logic        bit_clk = 1'b0;
    always #5 bit_clk = ~bit_clk;

    logic        reset_n, slip;
    logic [2:0]  in_bits;
    logic [29:0] word_out;
    logic        word_valid, locked;
    logic [1:0]  align_state;
    logic [7:0]  lock_loss_count;

    logic        reset_n_b, slip_b;
    logic [2:0]  in_bits_b;
    logic [29:0] word_out_b;
    logic        word_valid_b, locked_b;
    logic [1:0]  align_state_b;
    logic [7:0]  lock_loss_count_b;

    tmds_word_aligner u_dut (
        .bit_clk         (bit_clk),
        .reset_n         (reset_n),
        .in_bits         (in_bits),
        .slip            (slip),
        .word_out        (word_out),
        .word_valid      (word_valid),
        .locked          (locked),
        .align_state     (align_state),
        .lock_loss_count (lock_loss_count)
    );

    tmds_word_aligner #(.AUTO_LOCK(1'b0)) u_free (
        .bit_clk         (bit_clk),
        .reset_n         (reset_n_b),
        .in_bits         (in_bits_b),
        .slip            (slip_b),
        .word_out        (word_out_b),
        .word_valid      (word_valid_b),
        .locked          (locked_b),
        .align_state     (align_state_b),
        .lock_loss_count (lock_loss_count_b)
    );

    int unsigned cyc = 0;
    always @(posedge bit_clk) cyc <= cyc + 1;

    int          n_vec  = 0;
    int          n_fail = 0;
    logic [29:0] exp_q[$];
    int unsigned a_times[$];
    int unsigned b_times[$];
    logic [29:0] mon_exp;
    int unsigned start;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every strobe must match the oldest expected word
    always @(negedge bit_clk) begin
        if (word_valid === 1'b1) begin
            a_times.push_back(cyc);
            if (exp_q.size() == 0) begin
                n_vec++;
                n_fail++;
                $display("FAIL unexpected_strobe: word_out 0x%0h with no word expected", word_out);
            end else begin
                mon_exp = exp_q.pop_front();
                check("strobe_word", {2'b00, word_out}, {2'b00, mon_exp});
            end
        end
    end

    always @(negedge bit_clk) begin
        if (word_valid_b === 1'b1) b_times.push_back(cyc);
    end

    task automatic send_bit(input logic [2:0] b);
        in_bits = b;
        @(negedge bit_clk);
    endtask

    task automatic send_word(input logic [9:0] w0, input logic [9:0] w1, input logic [9:0] w2);
        for (int i = 0; i < 10; i++) send_bit({w2[i], w1[i], w0[i]});
    endtask

    initial begin
        reset_n   = 1'b0;
        reset_n_b = 1'b0;
        in_bits   = 3'b000;
        in_bits_b = 3'b101;
        slip      = 1'b0;
        slip_b    = 1'b0;
        repeat (3) @(negedge bit_clk);

        check("rst_word_out", word_out, 0);
        check("rst_word_valid", word_valid, 0);
        check("rst_locked", locked, 0);
        check("rst_state", align_state, 0);
        check("rst_loss", lock_loss_count, 0);
        reset_n = 1'b1;

        // Tokens starting three bits late
        repeat (3) send_bit(3'b000);
        repeat (4) send_word(TOK, 10'h0, 10'h0);
        check("locked_after_4", locked, 1);
        check("state_locked", align_state, 2);

        a_times.delete();
        exp_q.push_back({10'h0, 10'h0, TOK});
        exp_q.push_back({10'h0, 10'h0, TOK});
        repeat (2) send_word(TOK, 10'h0, 10'h0);
        #1;
        if (a_times.size() == 2) check("strobe_period", a_times[1] - a_times[0], 10);
        else                     check("strobe_count", a_times.size(), 2);

        exp_q.push_back({10'h0F3, 10'h155, TOK});
        send_word(TOK, 10'h155, 10'h0F3);

        // One extra bit: boundary words become shifted, tokens go off-phase
        exp_q.push_back({10'h0, 10'h0, 10'h156});
        exp_q.push_back({10'h0, 10'h0, 10'h157});
        exp_q.push_back({10'h0, 10'h0, 10'h157});
        send_bit(3'b000);
        repeat (3) send_word(TOK, 10'h0, 10'h0);
        check("unlock_locked", locked, 0);
        check("unlock_loss", lock_loss_count, 1);
        check("unlock_state", align_state, 0);

        repeat (4) send_word(TOK, 10'h0, 10'h0);
        check("relock", locked, 1);
        exp_q.push_back({10'h0, 10'h0, TOK});
        send_word(TOK, 10'h0, 10'h0);
        #1;
        check("queue_drained_a", exp_q.size(), 0);

        // Reset mid-word while locked
        for (int i = 0; i < 5; i++) send_bit({2'b00, TOK[i]});
        #2;
        reset_n = 1'b0;
        #1;
        check("midrst_word_out", word_out, 0);
        check("midrst_valid", word_valid, 0);
        check("midrst_locked", locked, 0);
        check("midrst_loss", lock_loss_count, 0);
        repeat (2) @(negedge bit_clk);
        reset_n = 1'b1;
        check("midrst_state", align_state, 0);

        // Token then non-token at the next boundary
        send_word(TOK, 10'h0, 10'h0);
        check("verify_state", align_state, 1);
        send_word(10'h1F0, 10'h0, 10'h0);
        check("verify_fail_state", align_state, 0);
        check("verify_fail_locked", locked, 0);
        repeat (5) @(negedge bit_clk);
        #1;
        check("queue_drained_b", exp_q.size(), 0);

        // Free-running framer with a slip pulse
        @(negedge bit_clk);
        b_times.delete();
        start     = cyc;
        reset_n_b = 1'b1;
        @(negedge bit_clk);
        check("free_locked", locked_b, 1);
        check("free_state", align_state_b, 2);
        repeat (22) @(negedge bit_clk);
        slip_b = 1'b1;
        @(negedge bit_clk);
        slip_b = 1'b0;
        repeat (30) @(negedge bit_clk);
        #1;
        if (b_times.size() == 5) begin
            check("free_first", b_times[0] - start, 10);
            check("free_gap1", b_times[1] - b_times[0], 10);
            check("free_gap_slip", b_times[2] - b_times[1], 11);
            check("free_gap3", b_times[3] - b_times[2], 10);
            check("free_gap4", b_times[4] - b_times[3], 10);
        end else begin
            check("free_strobe_count", b_times.size(), 5);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
